// File: rtl/block_sync_lane.sv
// Receive-side block synchronizer for one PCS lane: finds the 66-bit sync-header
// alignment by slipping one bit per bad header and tracks block lock.
module block_sync_lane #(
  parameter int unsigned NB_DATA_CODED    = 66,
  parameter int unsigned NB_SH            = 2,
  parameter int unsigned SH_CNT_LIMIT     = 64,
  parameter int unsigned SH_INVALID_LIMIT = 16,
  parameter int unsigned NB_OFFSET        = 7
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_block_lock,
  output logic [NB_OFFSET-1:0]     o_offset
);

  localparam int unsigned NB_CNT = $clog2(SH_CNT_LIMIT + 1);
  localparam int unsigned NB_INV = $clog2(SH_INVALID_LIMIT + 1);
  localparam int unsigned NB_WIN = 2 * NB_DATA_CODED;

  typedef enum logic {
    RESET_CNT,
    TEST_SH
  } state_e;

  state_e                   state_q;
  logic [NB_DATA_CODED-1:0] prev_word_q;
  logic [NB_OFFSET-1:0]     offset_q;
  logic [NB_CNT-1:0]        sh_cnt_q;
  logic [NB_INV-1:0]        sh_inv_cnt_q;
  logic                     lock_q;
  logic [NB_DATA_CODED-1:0] o_data_q;
  logic                     o_valid_q;

  logic                     accept;
  logic [NB_WIN-1:0]        win;
  logic [NB_OFFSET-1:0]     shamt;
  logic [NB_DATA_CODED-1:0] block;
  logic [NB_SH-1:0]         sh;
  logic                     sh_bad;
  logic [NB_CNT-1:0]        sh_cnt_d;
  logic [NB_INV-1:0]        sh_inv_cnt_d;
  logic [NB_OFFSET-1:0]     offset_slip;

  // Block extraction, header check and incremented window counters
  always_comb begin
    accept       = i_valid && i_enable;
    win          = {prev_word_q, i_data};
    // block starts offset bits into prev_word, i.e. win[NB_WIN-1-offset -: NB_DATA_CODED]
    shamt        = NB_OFFSET'(NB_DATA_CODED) - offset_q;
    block        = NB_DATA_CODED'(win >> shamt);
    sh           = block[NB_DATA_CODED-1 -: NB_SH];
    sh_bad       = !((sh == NB_SH'(1)) || (sh == NB_SH'(2)));
    // RESET_CNT means the counters were just cleared; count from zero
    sh_cnt_d     = ((state_q == RESET_CNT) ? '0 : sh_cnt_q) + NB_CNT'(1);
    sh_inv_cnt_d = ((state_q == RESET_CNT) ? '0 : sh_inv_cnt_q) + NB_INV'(sh_bad);
    offset_slip  = (offset_q == NB_OFFSET'(NB_DATA_CODED - 1)) ? '0 : offset_q + NB_OFFSET'(1);
  end

  // Lock FSM, slip control and registered output path
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= RESET_CNT;
      prev_word_q  <= '0;
      offset_q     <= '0;
      sh_cnt_q     <= '0;
      sh_inv_cnt_q <= '0;
      lock_q       <= 1'b0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
    end else if (accept) begin
      prev_word_q  <= i_data;
      o_data_q     <= block;
      o_valid_q    <= 1'b1;
      state_q      <= TEST_SH;
      sh_cnt_q     <= sh_cnt_d;
      sh_inv_cnt_q <= sh_inv_cnt_d;
      if (!lock_q) begin
        if (sh_bad) begin
          offset_q     <= offset_slip;
          sh_cnt_q     <= '0;
          sh_inv_cnt_q <= '0;
          state_q      <= RESET_CNT;
        end else if (sh_cnt_d == NB_CNT'(SH_CNT_LIMIT)) begin
          lock_q       <= 1'b1;
          sh_cnt_q     <= '0;
          sh_inv_cnt_q <= '0;
          state_q      <= RESET_CNT;
        end
      end else begin
        // loss of lock takes priority over a window closing on the same header
        if (sh_inv_cnt_d == NB_INV'(SH_INVALID_LIMIT)) begin
          lock_q       <= 1'b0;
          offset_q     <= offset_slip;
          sh_cnt_q     <= '0;
          sh_inv_cnt_q <= '0;
          state_q      <= RESET_CNT;
        end else if (sh_cnt_d == NB_CNT'(SH_CNT_LIMIT)) begin
          sh_cnt_q     <= '0;
          sh_inv_cnt_q <= '0;
          state_q      <= RESET_CNT;
        end
      end
    end else begin
      o_valid_q <= 1'b0;
    end
  end

  assign o_data       = o_data_q;
  assign o_valid      = o_valid_q;
  assign o_block_lock = lock_q;
  assign o_offset     = offset_q;

endmodule

// File: tb/tb_block_sync_lane.sv
// Directed bench for block_sync_lane: builds a bit-delayed block stream and
// checks slip, lock acquisition, hold, loss, gating and reset behaviour.
module tb_block_sync_lane;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic [65:0] i_data;
  logic [65:0] o_data;
  logic        o_valid;
  logic        o_block_lock;
  logic [6:0]  o_offset;

  int          total;
  int          bad;
  int          dly;
  logic [65:0] prev_blk;
  logic [65:0] exp_data;
  logic [65:0] zblk;

  block_sync_lane dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_block_lock (o_block_lock),
    .o_offset     (o_offset)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lane word = last dly bits of block a followed by first 66-dly bits of block b
  function automatic logic [65:0] mkword(input logic [65:0] a, input logic [65:0] b, input int d);
    logic [131:0] t;
    t = {a, b};
    t = t << (66 - d);
    return t[131:66];
  endfunction

  function automatic logic [65:0] rblk(input logic good);
    logic [1:0] h;
    if (good) h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    else      h = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    return {h, $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [65:0] blk);
    i_data   = mkword(prev_blk, blk, dly);
    i_valid  = 1'b1;
    i_enable = 1'b1;
    exp_data = prev_blk;
    prev_blk = blk;
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_enable = 1'b1;
    i_data   = '0;
    repeat (2) @(posedge i_clock);
    #3;
    i_reset  = 1'b1;
    prev_blk = '0;
  endtask

  // 13-bit delayed stream from reset: slips on words 0..12, locks on word 76
  task automatic relock13();
    dly = 13;
    send(zblk);
    chk("d13_w0_offset", 66'(o_offset), 66'd1);
    for (int i = 1; i <= 11; i++) send(zblk);
    chk("d13_w11_offset", 66'(o_offset), 66'd12);
    send(zblk);
    chk("d13_w12_offset", 66'(o_offset), 66'd13);
    for (int i = 13; i <= 75; i++) send(zblk);
    chk("d13_w75_nolock", 66'(o_block_lock), 66'd0);
    chk("d13_w75_offset", 66'(o_offset), 66'd13);
    send(zblk);
    chk("d13_w76_lock", 66'(o_block_lock), 66'd1);
    chk("d13_w76_data", o_data, exp_data);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    dly      = 0;
    prev_blk = '0;
    exp_data = '0;
    zblk     = {2'b01, 64'h0};
    i_data   = '0;

    // reset state
    do_reset();
    chk("rst_data", o_data, 66'd0);
    chk("rst_valid", 66'(o_valid), 66'd0);
    chk("rst_lock", 66'(o_block_lock), 66'd0);
    chk("rst_offset", 66'(o_offset), 66'd0);

    // stream shifted by 1 bit: first-word slip lands on the right offset
    dly = 1;
    send(zblk);
    chk("d1_w0_offset", 66'(o_offset), 66'd1);
    chk("d1_w0_valid", 66'(o_valid), 66'd1);
    chk("d1_w0_data", o_data, 66'd0);
    chk("d1_w0_lock", 66'(o_block_lock), 66'd0);
    for (int i = 1; i <= 63; i++) send(zblk);
    chk("d1_w63_nolock", 66'(o_block_lock), 66'd0);
    send(zblk);
    chk("d1_w64_lock", 66'(o_block_lock), 66'd1);
    chk("d1_w64_offset", 66'(o_offset), 66'd1);
    chk("d1_w64_data", o_data, exp_data);
    for (int i = 0; i < 8; i++) begin
      send(rblk(1'b1));
      chk("d1_data", o_data, exp_data);
      chk("d1_offset", 66'(o_offset), 66'd1);
    end

    // offset wrap 65 -> 0 via forced slips on all-zero words
    do_reset();
    dly = 0;
    for (int i = 0; i < 65; i++) send(66'd0);
    chk("wrap_offset65", 66'(o_offset), 66'd65);
    send(zblk);
    chk("wrap_offset0", 66'(o_offset), 66'd0);
    for (int i = 1; i <= 63; i++) send(zblk);
    chk("wrap_nolock", 66'(o_block_lock), 66'd0);
    send(zblk);
    chk("wrap_lock", 66'(o_block_lock), 66'd1);
    chk("wrap_lock_offset", 66'(o_offset), 66'd0);
    chk("wrap_data", o_data, exp_data);

    // 13-bit delay, then hold with 15 bad headers in one window
    do_reset();
    relock13();
    for (int i = 0; i < 10; i++) begin
      send(rblk(1'b1));
      chk("hold_data", o_data, exp_data);
    end
    for (int i = 0; i < 15; i++) send(rblk(1'b0));
    chk("bad15_lock", 66'(o_block_lock), 66'd1);
    for (int i = 0; i < 40; i++) begin
      send(rblk(1'b1));
      chk("bad15_hold_lock", 66'(o_block_lock), 66'd1);
    end
    chk("bad15_offset", 66'(o_offset), 66'd13);
    chk("bad15_data", o_data, exp_data);

    // gating while locked
    send(rblk(1'b1));
    chk("gate_valid1", 66'(o_valid), 66'd1);
    i_valid = 1'b0;
    i_data  = rblk(1'b0);
    @(posedge i_clock);
    #1;
    chk("gate_valid0", 66'(o_valid), 66'd0);
    send(rblk(1'b1));
    chk("gate_resume_data", o_data, exp_data);
    chk("gate_resume_valid", 66'(o_valid), 66'd1);
    i_enable = 1'b0;
    i_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_data = rblk(1'b0);
      @(posedge i_clock);
      #1;
      chk("gate_en_valid0", 66'(o_valid), 66'd0);
    end
    chk("gate_en_lock", 66'(o_block_lock), 66'd1);
    chk("gate_en_offset", 66'(o_offset), 66'd13);

    // 16 bad headers in one window: lock drops on the 16th, offset slips
    for (int i = 0; i < 16; i++) send(rblk(1'b0));
    chk("loss_pre_lock", 66'(o_block_lock), 66'd1);
    chk("loss_pre_offset", 66'(o_offset), 66'd13);
    send(rblk(1'b1));
    chk("loss_lock", 66'(o_block_lock), 66'd0);
    chk("loss_offset", 66'(o_offset), 66'd14);
    chk("loss_data", o_data, exp_data);

    // 16th bad header also the 64th header of the window
    do_reset();
    relock13();
    for (int i = 0; i < 47; i++) send(rblk(1'b1));
    for (int i = 0; i < 16; i++) send(rblk(1'b0));
    chk("edge64_pre_lock", 66'(o_block_lock), 66'd1);
    send(rblk(1'b1));
    chk("edge64_lock", 66'(o_block_lock), 66'd0);
    chk("edge64_offset", 66'(o_offset), 66'd14);

    // async reset between edges while locked
    do_reset();
    relock13();
    for (int i = 0; i < 3; i++) send(rblk(1'b1));
    chk("arst_pre_valid", 66'(o_valid), 66'd1);
    i_valid = 1'b0;
    #3;
    i_reset = 1'b0;
    #1;
    chk("arst_data", o_data, 66'd0);
    chk("arst_valid", 66'(o_valid), 66'd0);
    chk("arst_lock", 66'(o_block_lock), 66'd0);
    chk("arst_offset", 66'(o_offset), 66'd0);
    @(posedge i_clock);
    #3;
    i_reset  = 1'b1;
    prev_blk = '0;
    relock13();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
